// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_rx
// Brief    : 8N1 UART receiver with centre sampling, framing-error strobe and
//            break hold-off. Optional macro UART_RX_MAJORITY_EN enables a
//            2-of-3 majority vote around each sample point.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int BIT_CNT  = CLK_FREQ / BAUD;
    localparam int HALF_CNT = BIT_CNT / 2;
    localparam int CNT_W    = ($clog2(BIT_CNT) < 9) ? 9 : $clog2(BIT_CNT);
`ifdef UART_RX_MAJORITY_EN
    localparam int DEC_LAG  = 1;
`else
    localparam int DEC_LAG  = 0;
`endif
    // START decides one cycle late with voting; later bits keep a full-bit
    // period, so the whole sampling grid slides by that one cycle.
    localparam logic [CNT_W-1:0] c_START_DEC = CNT_W'(HALF_CNT - 1 + DEC_LAG);
    localparam logic [CNT_W-1:0] c_BIT_DEC   = CNT_W'(BIT_CNT - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_START     = 3'd1;
    localparam logic [2:0] c_DATA      = 3'd2;
    localparam logic [2:0] c_STOP      = 3'd3;
    localparam logic [2:0] c_WAIT_IDLE = 3'd4;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shreg;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_frame_err;
    logic             w_line;
    logic             w_fall;
    logic             w_start_hit;
    logic             w_bit_hit;
    logic             w_shift_en;
    logic             w_load;
    logic             w_ferr;
    logic             w_busy;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= uart_rxd;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
        end
    end

    assign w_line = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync2) | (r_hist[0] & r_sync2);
`else
    assign w_line = r_sync2;
`endif

    assign w_fall      = r_prev & ~r_sync2;
    assign w_start_hit = (r_cnt == c_START_DEC);
    assign w_bit_hit   = (r_cnt == c_BIT_DEC);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_fall) w_state_nxt = c_START;
            end
            c_START: begin
                if (w_start_hit) w_state_nxt = w_line ? c_IDLE : c_DATA;
            end
            c_DATA: begin
                if (w_bit_hit && (r_bit_idx == 3'd7)) w_state_nxt = c_STOP;
            end
            c_STOP: begin
                // Leaving at the stop centre allows zero-gap back-to-back frames.
                if (w_bit_hit) w_state_nxt = w_line ? c_IDLE : c_WAIT_IDLE;
            end
            c_WAIT_IDLE: begin
                if (r_sync2) w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_shift_en = (r_state == c_DATA) && w_bit_hit;
        w_load     = (r_state == c_STOP) && w_bit_hit && w_line;
        w_ferr     = (r_state == c_STOP) && w_bit_hit && !w_line;
        w_busy     = (r_state != c_IDLE);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_cnt          <= '0;
            r_bit_idx      <= 3'd0;
            r_shreg        <= 8'h00;
            r_rx_data      <= 8'h00;
            r_rx_valid     <= 1'b0;
            r_rx_frame_err <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_shift_en) begin
                r_cnt <= '0;
            end else if ((r_state == c_START) || (r_state == c_DATA) || (r_state == c_STOP)) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (r_state == c_START) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_shift_en) begin
                r_shreg[r_bit_idx] <= w_line;
            end

            if (w_load) begin
                r_rx_data <= r_shreg;
            end
            r_rx_valid     <= w_load;
            r_rx_frame_err <= w_ferr;
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_frame_err = r_rx_frame_err;
    assign rx_busy      = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_byte_rx
// Brief    : Scoreboard bench for uart_byte_rx: directed serial frames, with a
//            monitor popping expected strobes as the receiver emits them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_byte_rx;

    localparam int BIT_NS = 8680;
`ifdef UART_RX_MAJORITY_EN
    localparam int GLITCH_BUSY = 218;
`else
    localparam int GLITCH_BUSY = 217;
`endif

    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
        logic       gap_chk;
    } exp_t;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rxd  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    int      n_tests = 0;
    int      n_fail  = 0;
    longint  cyc     = 0;
    longint  last_valid_cyc = 0;
    int      busy_run = 0;
    int      last_busy_run = 0;
    logic    prev_strobe = 1'b0;
    exp_t    q[$];

    uart_byte_rx dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .uart_rxd     (uart_rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Leaves the line at the stop-bit level so a broken stop can be extended.
    task automatic send_byte(input logic [7:0] d, input logic stop);
        uart_rxd = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            #BIT_NS;
        end
        uart_rxd = stop;
        #BIT_NS;
    endtask

    always @(negedge sys_clk) begin
        exp_t e;
        cyc++;
        if (rx_busy) begin
            busy_run++;
        end else begin
            if (busy_run != 0) last_busy_run = busy_run;
            busy_run = 0;
        end
        if (rx_valid || rx_frame_err) begin
            check("strobe_width", {31'd0, prev_strobe}, 32'd0);
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got valid=%0b ferr=%0b data=%0h, expected none",
                         rx_valid, rx_frame_err, rx_data);
            end else begin
                e = q.pop_front();
                check("strobe_kind", {30'd0, rx_frame_err, rx_valid}, {30'd0, e.ferr, ~e.ferr});
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                if (e.gap_chk && rx_valid) begin
                    n_tests++;
                    if ((cyc - last_valid_cyc) < 4337 || (cyc - last_valid_cyc) > 4343) begin
                        n_fail++;
                        $display("FAIL b2b_gap: got %0d cycles, expected 4340+-3", cyc - last_valid_cyc);
                    end
                end
            end
            if (rx_valid) last_valid_cyc = cyc;
        end
        prev_strobe = rx_valid | rx_frame_err;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no completion, expected end of sequence");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        sys_rst_n = 1'b0;
        uart_rxd  = 1'b1;
        repeat (5) begin
            @(negedge sys_clk);
            check("reset_outputs", {21'd0, rx_data, rx_valid, rx_frame_err, rx_busy}, 32'd0);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        check("post_reset_idle", {21'd0, rx_data, rx_valid, rx_frame_err, rx_busy}, 32'd0);

        @(posedge sys_clk);
        #3;

        q.push_back({1'b0, 8'h55, 1'b0});
        send_byte(8'h55, 1'b1);
        #BIT_NS;
        check("single_busy_low", {31'd0, rx_busy}, 32'd0);
        check("single_data_hold", {24'd0, rx_data}, 32'h55);

        q.push_back({1'b0, 8'hA3, 1'b0});
        q.push_back({1'b0, 8'h00, 1'b1});
        q.push_back({1'b0, 8'hFF, 1'b1});
        send_byte(8'hA3, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        #BIT_NS;

        uart_rxd = 1'b0;
        #100;
        uart_rxd = 1'b1;
        #(2 * BIT_NS);
        check("glitch_busy_len", last_busy_run, GLITCH_BUSY);
        check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);

        q.push_back({1'b1, 8'hFF, 1'b0});
        send_byte(8'h3C, 1'b0);
        #(2 * BIT_NS);
        check("break_busy_held", {31'd0, rx_busy}, 32'd1);
        uart_rxd = 1'b1;
        #(2 * BIT_NS);
        q.push_back({1'b0, 8'h81, 1'b0});
        send_byte(8'h81, 1'b1);
        #BIT_NS;

        uart_rxd = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 4; i++) begin
            uart_rxd = (8'hC7 >> i) & 8'h01;
            #BIT_NS;
        end
        uart_rxd = 1'b0;
        #(BIT_NS / 2);
        sys_rst_n = 1'b0;
        #2;
        check("async_reset_outputs", {21'd0, rx_data, rx_valid, rx_frame_err, rx_busy}, 32'd0);
        #98;
        uart_rxd  = 1'b1;
        sys_rst_n = 1'b1;
        #(2 * BIT_NS);
        check("after_midframe_reset", {21'd0, rx_data, rx_valid, rx_frame_err, rx_busy}, 32'd0);
        q.push_back({1'b0, 8'h12, 1'b0});
        send_byte(8'h12, 1'b1);
        #BIT_NS;

`ifdef UART_RX_MAJORITY_EN
        q.push_back({1'b0, 8'h55, 1'b0});
        uart_rxd = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            uart_rxd = (8'h55 >> i) & 8'h01;
            if (i == 3) begin
                #(BIT_NS / 2 - 10);
                uart_rxd = 1'b1;
                #20;
                uart_rxd = 1'b0;
                #(BIT_NS / 2 - 10);
            end else begin
                #BIT_NS;
            end
        end
        uart_rxd = 1'b1;
        #(2 * BIT_NS);
`endif

        check("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_byte_rx.md
# uart_byte_rx

- Asynchronous serial receiver: 8 data bits, no parity, 1 stop bit, LSB first.
- Sits directly behind the `uart_rxd` pin inside `top` and feeds received bytes to the command/DDS frame logic.
- Synchronises the line, validates the start bit and samples each bit at its centre.
- Emits one single-cycle strobe per byte, or a framing-error strobe for a bad stop bit.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: sys_clk frequency in Hz.
- `BAUD`, 115200: line rate in baud.
- Derived, not overridable: `BIT_CNT = CLK_FREQ/BAUD` (integer division; 434), `HALF_CNT = BIT_CNT/2` (217).

Ports:
- `sys_clk`, in, 1: the block's single clock.
- `sys_rst_n`, in, 1: reset, asynchronous, active-low.
- `uart_rxd`, in, 1: serial line, idles high, asynchronous to sys_clk.
- `rx_data`, out, 8: last good byte; holds until the next good byte.
- `rx_valid`, out, 1: one-cycle strobe; `rx_data` is new in the same cycle.
- `rx_frame_err`, out, 1: one-cycle strobe when the stop bit samples 0.
- `rx_busy`, out, 1: high in every state except IDLE.

## Operation
- Line synchroniser: two flops, both reset to 1, followed by a third flop holding the previous value for edge detection.
- Bit counter: `cnt`, 9 bits minimum, sized for `BIT_CNT-1`. Sample point is `cnt == BIT_CNT-1`, or `HALF_CNT-1` in START. `cnt` clears on every state change.
- State machine:
  - IDLE: on a synchronised falling edge (previous 1, current 0), go to START.
  - START: at the half-bit sample, line 0 goes to DATA with `bit_idx=0`. Line 1 is a glitch: return to IDLE with no strobe.
  - DATA: at each sample, shift the line into `shreg[bit_idx]`. After bit 7, go to STOP.
  - STOP: at the sample, line 1 loads `rx_data<=shreg`, pulses `rx_valid`, and goes to IDLE. Line 0 pulses `rx_frame_err`, leaves `rx_data` unchanged, and goes to WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronised line reads 1, then go to IDLE. This prevents a held break from being taken as a new start.
- Returning to IDLE at the stop-bit centre lets back-to-back frames with no idle gap be received.
- `rx_valid` and `rx_frame_err` are never high in the same cycle. Each is high for exactly one cycle per frame.
- Reset, asynchronous, any state:
  - State goes to IDLE; `cnt`, `bit_idx` and `shreg` clear; synchroniser flops set to 1.
  - `rx_data=8'h00`, `rx_valid=0`, `rx_frame_err=0`, `rx_busy=0`.
  - A partial frame is discarded. After release, a start is recognised only after the line has been seen high and then falls.

## Timing
- t0 is the sys_clk edge at which the synchronised line first reads 0 in IDLE. This is 2–3 cycles after the pin falls.
- Start-bit sample: t0+`HALF_CNT` (217 cycles).
- Data bit k sample: t0+`HALF_CNT`+(k+1)·`BIT_CNT`.
- Stop sample: t0+`HALF_CNT`+9·`BIT_CNT` = t0+4123. The strobe is registered and visible from t0+4124 for one cycle.
- `rx_busy` rises at t0+1 and falls in the same cycle the strobe is visible. In the framing-error case it falls on leaving WAIT_IDLE.
- Tolerance: at most ±4% baud mismatch, which follows from centre sampling.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each sample point (start, data, stop) uses the 2-of-3 majority of the synchronised line at `cnt` = S-1, S and S+1.
  - The decision and all state actions occur at S+1, so every strobe is 1 cycle later (t0+4125 visible).
  - A 1-cycle glitch at a bit centre does not corrupt data.
- Undefined: a single sample at S with the timing above. No majority logic is present.

## Test plan
All serial stimulus uses a 50 MHz clock and 8680 ns bit time.
- Reset: hold `sys_rst_n=0` for 100 ns. `rx_data=8'h00`, `rx_valid=0`, `rx_frame_err=0` and `rx_busy=0` throughout and after release with the line idle.
- Single byte: send 8'h55 → exactly one `rx_valid` pulse of 1 cycle, `rx_data=8'h55`, no `rx_frame_err`; `rx_busy` low afterwards.
- Back-to-back: send 8'hA3, 8'h00, 8'hFF with zero idle between frames → three `rx_valid` pulses carrying A3, 00, FF in order; pulse spacing is 4340 cycles ±3.
- Glitch: drive the line low for 100 ns, then high → no strobe; `rx_busy` high for 217 cycles (218 with the macro), then low.
- Framing: send 8'h3C with stop bit 0 and hold low for 2 bit times, then send 8'h81 → one `rx_frame_err` pulse, no `rx_valid`, `rx_data` keeps its prior value. 8'h81 is then received correctly.
- Reset mid-frame: assert `sys_rst_n` low during bit 4 of 8'hC7 → outputs return to reset values asynchronously. After release, idle high and send 8'h12 → `rx_valid` with 8'h12 only. With `UART_RX_MAJORITY_EN`, an added 20 ns pulse at the bit-3 centre of 8'h55 still yields 8'h55.
